// File: rtl/dec_pkg.sv
// Shared decode constants and the decoded-bundle type used by dec_stage and the execute side.
// pc/imm fields are sized for the widest datapath; narrower stages use the low XLEN bits.
package dec_pkg;

    localparam int DEC_XLEN_MAX = 64;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    localparam logic [2:0] FUNCT3_ADD  = 3'b000;
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SLT  = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU = 3'b011;
    localparam logic [2:0] FUNCT3_XOR  = 3'b100;
    localparam logic [2:0] FUNCT3_SR   = 3'b101;
    localparam logic [2:0] FUNCT3_OR   = 3'b110;
    localparam logic [2:0] FUNCT3_AND  = 3'b111;

    localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
    localparam logic [3:0] ALU_OP_SLL  = 4'b0001;
    localparam logic [3:0] ALU_OP_SLT  = 4'b0010;
    localparam logic [3:0] ALU_OP_SLTU = 4'b0011;
    localparam logic [3:0] ALU_OP_XOR  = 4'b0100;
    localparam logic [3:0] ALU_OP_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OP_OR   = 4'b0110;
    localparam logic [3:0] ALU_OP_AND  = 4'b0111;
    localparam logic [3:0] ALU_OP_SUB  = 4'b1000;
    localparam logic [3:0] ALU_OP_SRA  = 4'b1101;

    localparam logic [2:0] COM_OP_EQ  = 3'b000;
    localparam logic [2:0] COM_OP_NE  = 3'b001;
    localparam logic [2:0] COM_OP_LT  = 3'b100;
    localparam logic [2:0] COM_OP_GE  = 3'b101;
    localparam logic [2:0] COM_OP_LTU = 3'b110;
    localparam logic [2:0] COM_OP_GEU = 3'b111;

    // Loads, stores and system ops carry funct3 in the low bits: 011xx, 010xx, 10xxx.
    localparam logic [4:0] INST_NONE   = 5'b00000;
    localparam logic [4:0] INST_IMM    = 5'b00001;
    localparam logic [4:0] INST_REG    = 5'b00010;
    localparam logic [4:0] INST_UPP    = 5'b00011;
    localparam logic [4:0] INST_AUIPC  = 5'b00100;
    localparam logic [4:0] INST_JUMP   = 5'b00101;
    localparam logic [4:0] INST_JUMPR  = 5'b00110;
    localparam logic [4:0] INST_BRANCH = 5'b00111;

    typedef struct packed {
        logic [DEC_XLEN_MAX-1:0] pc;
        logic [4:0]              rd;
        logic [4:0]              rs1;
        logic [4:0]              rs2;
        logic [DEC_XLEN_MAX-1:0] imm;
        logic [3:0]              alu_op;
        logic [2:0]              com_op;
        logic                    is_mem_sign;
        logic [4:0]              inst_type;
        logic                    illegal;
    } dec_bundle_t;

    function automatic logic [DEC_XLEN_MAX-1:0] sext32(input logic [31:0] v);
        return {{(DEC_XLEN_MAX-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/dec_fifo.sv
// Instruction queue for the decode stage: DEPTH entries of {inst, pc}, synchronous flush.
module dec_fifo
    import dec_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            push,
    input  logic [31:0]     push_inst,
    input  logic [XLEN-1:0] push_pc,
    input  logic            pop,
    output logic            head_valid,
    output logic [31:0]     head_inst,
    output logic [XLEN-1:0] head_pc,
    output logic            full,
    output logic [CW-1:0]   count
);

    localparam int W = 32 + XLEN;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {push_inst, push_pc};
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign head_valid = (count_q != '0);
    assign head_inst  = mem_q[rd_ptr_q][W-1:XLEN];
    assign head_pc    = mem_q[rd_ptr_q][XLEN-1:0];
    assign full       = (count_q == CW'(DEPTH));
    assign count      = count_q;

endmodule

// File: rtl/dec_stage.sv
// RV32/RV64 decode stage: instruction queue, combinational decode of the head, output register.
// Define DEC_ILLEGAL_EN to build the illegal-instruction checker; otherwise out_illegal is 0.
module dec_stage
    import dec_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int ID_W  = 5
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [ID_W-1:0]            out_rd,
    output logic [ID_W-1:0]            out_rs1,
    output logic [ID_W-1:0]            out_rs2,
    output logic [XLEN-1:0]            out_imm,
    output logic [3:0]                 out_alu_op,
    output logic [2:0]                 out_com_op,
    output logic                       out_is_mem_sign,
    output logic [4:0]                 out_inst_type,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    logic            push, pop, full, head_valid, load;
    logic [31:0]     head_inst;
    logic [XLEN-1:0] head_pc;
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [DEC_XLEN_MAX-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            dec_illegal;
    dec_bundle_t     dec;
    dec_bundle_t     out_q, out_d;
    logic            out_valid_q, out_valid_d;

    // No bypass: a full queue refuses input even if the head pops this cycle.
    assign in_ready = reset_n & ~flush & ~full;
    assign push     = in_valid & in_ready;
    assign load     = head_valid & (~out_valid_q | out_ready);
    assign pop      = load & ~flush;

    dec_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .push       (push),
        .push_inst  (in_inst),
        .push_pc    (in_pc),
        .pop        (pop),
        .head_valid (head_valid),
        .head_inst  (head_inst),
        .head_pc    (head_pc),
        .full       (full),
        .count      (count)
    );

    assign opcode = head_inst[6:0];
    assign f3     = head_inst[14:12];

    assign imm_i = sext32({{20{head_inst[31]}}, head_inst[31:20]});
    assign imm_s = sext32({{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]});
    assign imm_b = sext32({{19{head_inst[31]}}, head_inst[31], head_inst[7],
                           head_inst[30:25], head_inst[11:8], 1'b0});
    assign imm_u = sext32({head_inst[31:12], 12'b0});
    assign imm_j = sext32({{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
                           head_inst[20], head_inst[30:21], 1'b0});

`ifdef DEC_ILLEGAL_EN
    logic [6:0] funct7;
    assign funct7 = head_inst[31:25];

    always_comb begin
        dec_illegal = (head_inst[1:0] != 2'b11);
        case (opcode)
            OPCODE_LOAD:
                if (f3 == 3'b111 || (XLEN == 32 && f3 == 3'b011)) dec_illegal = 1'b1;
            OPCODE_STORE:
                if (f3[2] || (XLEN == 32 && f3 == 3'b011)) dec_illegal = 1'b1;
            OPCODE_BRANCH:
                if (f3 == 3'b010 || f3 == 3'b011) dec_illegal = 1'b1;
            OPCODE_OP:
                if (!(funct7 == 7'h00 ||
                      (funct7 == 7'h20 && (f3 == FUNCT3_ADD || f3 == FUNCT3_SR))))
                    dec_illegal = 1'b1;
            OPCODE_OP_IMM, OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL,
            OPCODE_JALR, OPCODE_SYSTEM: ;
            default: dec_illegal = 1'b1;
        endcase
    end
`else
    assign dec_illegal = 1'b0;
`endif

    always_comb begin
        dec             = '0;
        dec.pc          = DEC_XLEN_MAX'(head_pc);
        dec.rd          = head_inst[11:7];
        dec.rs1         = head_inst[19:15];
        dec.rs2         = head_inst[24:20];
        dec.alu_op      = ALU_OP_ADD;
        dec.com_op      = COM_OP_EQ;
        dec.is_mem_sign = ~f3[2];
        dec.illegal     = dec_illegal;
        case (opcode)
            OPCODE_OP_IMM: begin
                dec.imm       = imm_i;
                dec.inst_type = INST_IMM;
                dec.alu_op    = {head_inst[30] & (f3 == FUNCT3_SR), f3};
            end
            OPCODE_OP: begin
                dec.inst_type = INST_REG;
                dec.alu_op    = {head_inst[30] & (f3 == FUNCT3_ADD || f3 == FUNCT3_SR), f3};
            end
            OPCODE_LOAD: begin
                dec.imm       = imm_i;
                dec.inst_type = {3'b011, f3[1:0]};
            end
            OPCODE_STORE: begin
                dec.imm       = imm_s;
                dec.inst_type = {3'b010, f3[1:0]};
            end
            OPCODE_LUI: begin
                dec.imm       = imm_u;
                dec.inst_type = INST_UPP;
            end
            OPCODE_AUIPC: begin
                dec.imm       = imm_u;
                dec.inst_type = INST_AUIPC;
            end
            OPCODE_JAL: begin
                dec.imm       = imm_j;
                dec.inst_type = INST_JUMP;
            end
            OPCODE_JALR: begin
                dec.imm       = imm_i;
                dec.inst_type = INST_JUMPR;
            end
            OPCODE_BRANCH: begin
                dec.imm       = imm_b;
                dec.com_op    = f3;
                dec.inst_type = INST_BRANCH;
            end
            OPCODE_SYSTEM: begin
                dec.imm       = imm_i;
                dec.alu_op    = {2'b01, f3[1:0]};
                dec.inst_type = {2'b10, f3};
            end
            default: dec.inst_type = INST_NONE;
        endcase
    end

    // Fields hold their last value when valid drops so a stalled bundle never changes.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_d       = dec;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_pc          = out_q.pc[XLEN-1:0];
    assign out_rd          = ID_W'(out_q.rd);
    assign out_rs1         = ID_W'(out_q.rs1);
    assign out_rs2         = ID_W'(out_q.rs2);
    assign out_imm         = out_q.imm[XLEN-1:0];
    assign out_alu_op      = out_q.alu_op;
    assign out_com_op      = out_q.com_op;
    assign out_is_mem_sign = out_q.is_mem_sign;
    assign out_inst_type   = out_q.inst_type;
    assign out_illegal     = out_q.illegal;

endmodule
